// File: rtl/y86_execute_stage_if.sv
// Handshake and data bundle between decode, the Y86 execute stage and the register-file write port.
interface y86_execute_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [31:0] valA;
    logic [31:0] valB;
    logic [31:0] valC;
    logic [2:0]  dstE;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] valE_out;
    logic [2:0]  dstE_out;
    logic        Write_out;
    logic        Cnd;
    logic [2:0]  cc;
    logic        halted;

    modport master (
        output in_valid, icode, ifun, valA, valB, valC, dstE, out_ready,
        input  in_ready, out_valid, valE_out, dstE_out, Write_out, Cnd, cc, halted
    );

    modport slave (
        input  in_valid, icode, ifun, valA, valB, valC, dstE, out_ready,
        output in_ready, out_valid, valE_out, dstE_out, Write_out, Cnd, cc, halted
    );
endinterface

// File: rtl/y86_execute_stage.sv
// Y86 execute stage: ALU, condition codes, Cnd evaluation and a one-entry registered result
// slot feeding the register-file write port; stops permanently on halt or an invalid icode.
module y86_execute_stage #(
    parameter logic [2:0]  STACK_REG  = 3'd4,
    parameter logic [31:0] WORD_BYTES = 32'd4
) (
    input logic                  CLK,
    input logic                  reset,
    y86_execute_stage_if.slave   bus
);

    typedef enum logic {StRun, StHalt} state_e;

    state_e      r_state;
    state_e      w_state_d;

    logic        r_out_valid;
    logic [31:0] r_valE;
    logic [2:0]  r_dstE;
    logic        r_write;
    logic        r_cnd;
    logic [2:0]  r_cc;

    logic        w_xfer;
    logic        w_zf;
    logic        w_sf;
    logic        w_of;
    logic        w_cond;
    logic [31:0] w_alu;
    logic        w_alu_of;
    logic [31:0] w_valE;
    logic [2:0]  w_dstE;
    logic        w_write;
    logic        w_cnd;
    logic        w_cc_we;
    logic        w_halt_insn;

    assign bus.in_ready  = (r_state == StRun) & (~r_out_valid | bus.out_ready);
    assign w_xfer        = bus.in_valid & bus.in_ready;

    assign bus.out_valid = r_out_valid;
    assign bus.valE_out  = r_valE;
    assign bus.dstE_out  = r_dstE;
    assign bus.Write_out = r_out_valid & r_write;
    assign bus.Cnd       = r_cnd;
    assign bus.cc        = r_cc;
    assign bus.halted    = (r_state == StHalt);

    assign w_zf = r_cc[2];
    assign w_sf = r_cc[1];
    assign w_of = r_cc[0];

    // Condition uses the codes held before this instruction's own update.
    always_comb begin
        w_cond = 1'b0;
        case (bus.ifun)
            4'h0:    w_cond = 1'b1;
            4'h1:    w_cond = (w_sf ^ w_of) | w_zf;
            4'h2:    w_cond = w_sf ^ w_of;
            4'h3:    w_cond = w_zf;
            4'h4:    w_cond = ~w_zf;
            4'h5:    w_cond = ~(w_sf ^ w_of);
            4'h6:    w_cond = ~(w_sf ^ w_of) & ~w_zf;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_alu    = '0;
        w_alu_of = 1'b0;
        case (bus.ifun)
            4'h0: begin
                w_alu    = bus.valB + bus.valA;
                w_alu_of = (bus.valA[31] == bus.valB[31]) & (w_alu[31] != bus.valB[31]);
            end
            4'h1: begin
                w_alu    = bus.valB - bus.valA;
                w_alu_of = (bus.valA[31] != bus.valB[31]) & (w_alu[31] != bus.valB[31]);
            end
            4'h2:    w_alu = bus.valB & bus.valA;
            4'h3:    w_alu = bus.valB ^ bus.valA;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_valE      = '0;
        w_dstE      = bus.dstE;
        w_write     = 1'b0;
        w_cnd       = 1'b0;
        w_cc_we     = 1'b0;
        w_halt_insn = 1'b0;
        case (bus.icode)
            4'h0: w_halt_insn = 1'b1;
            4'h1: ;
            4'h2: begin
                w_valE  = bus.valA;
                w_cnd   = w_cond;
                w_write = w_cond;
            end
            4'h3: begin
                w_valE  = bus.valC;
                w_write = 1'b1;
            end
            4'h4, 4'h5: w_valE = bus.valB + bus.valC;
            4'h6: begin
                if (bus.ifun <= 4'h3) begin
                    w_valE  = w_alu;
                    w_write = 1'b1;
                    w_cc_we = 1'b1;
                end else begin
                    w_halt_insn = 1'b1;
                end
            end
            4'h7: w_cnd = w_cond;
            4'h8, 4'hA: begin
                w_valE  = bus.valB - WORD_BYTES;
                w_dstE  = STACK_REG;
                w_write = 1'b1;
            end
            4'h9, 4'hB: begin
                w_valE  = bus.valB + WORD_BYTES;
                w_dstE  = STACK_REG;
                w_write = 1'b1;
            end
            default: w_halt_insn = 1'b1;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        if (r_state == StRun && w_xfer && w_halt_insn) begin
            w_state_d = StHalt;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_valE      <= '0;
            r_dstE      <= '0;
            r_write     <= 1'b0;
            r_cnd       <= 1'b0;
            r_cc        <= 3'b100;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_valE      <= w_valE;
                r_dstE      <= w_dstE;
                r_write     <= w_write;
                r_cnd       <= w_cnd;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_xfer && w_cc_we) begin
                r_cc <= {(w_alu == 32'd0), w_alu[31], w_alu_of};
            end
        end
    end

endmodule

// File: tb/tb_y86_execute_stage.sv
// Bench for y86_execute_stage: directed vector table, handshake/halt/reset sequences and a
// randomized run checked against a transaction-level model of the Y86 execute rules.
module tb_y86_execute_stage;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    y86_execute_stage_if bus ();

    y86_execute_stage dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [31:0] valA;
        logic [31:0] valB;
        logic [31:0] valC;
        logic [2:0]  dstE;
        logic [31:0] exp_valE;
        logic        exp_write;
        logic [2:0]  exp_dst;
        logic        exp_cnd;
        logic [2:0]  exp_cc;
    } vec_t;

    typedef struct {
        logic [31:0] valE;
        logic        write;
        logic [2:0]  dst;
        logic        cnd;
        logic [2:0]  cc;
        logic        halt;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_met(input logic [3:0] fn, input logic [2:0] c);
        logic zf, less;
        zf   = c[2];
        less = (c[1] != c[0]);
        case (fn)
            4'h0:    return 1'b1;
            4'h1:    return less || zf;
            4'h2:    return less;
            4'h3:    return zf;
            4'h4:    return !zf;
            4'h5:    return !less;
            4'h6:    return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: signed overflow judged from the exact (64-bit) result, not from sign bits.
    function automatic res_t model(input logic [3:0] ic, input logic [3:0] fn,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] c, input logic [2:0] d,
                                   input logic [2:0] cc_in);
        res_t r;
        longint sa, sb, exact;
        r = '{valE: 32'd0, write: 1'b0, dst: d, cnd: 1'b0, cc: cc_in, halt: 1'b0};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (ic)
            4'h2: begin r.valE = a; r.cnd = cond_met(fn, cc_in); r.write = r.cnd; end
            4'h3: begin r.valE = c; r.write = 1'b1; end
            4'h4, 4'h5: r.valE = b + c;
            4'h6: begin
                if (fn > 4'h3) begin
                    r.halt = 1'b1;
                end else begin
                    exact = 0;
                    if (fn == 4'h0) begin r.valE = b + a; exact = sb + sa; end
                    if (fn == 4'h1) begin r.valE = b - a; exact = sb - sa; end
                    if (fn == 4'h2) begin r.valE = b & a; exact = longint'($signed(r.valE)); end
                    if (fn == 4'h3) begin r.valE = b ^ a; exact = longint'($signed(r.valE)); end
                    r.write = 1'b1;
                    r.cc = {r.valE == 32'd0, $signed(r.valE) < 0,
                            (exact > 64'sd2147483647) || (exact < -64'sd2147483648)};
                end
            end
            4'h7: r.cnd = cond_met(fn, cc_in);
            4'h8, 4'hA: begin r.valE = b - 32'd4; r.write = 1'b1; r.dst = 3'd4; end
            4'h9, 4'hB: begin r.valE = b + 32'd4; r.write = 1'b1; r.dst = 3'd4; end
            4'h1: ;
            default: r.halt = 1'b1;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [2:0] d);
        bus.icode = ic;
        bus.ifun  = fn;
        bus.valA  = a;
        bus.valB  = b;
        bus.valC  = c;
        bus.dstE  = d;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    vec_t vecs[18];

    // Random-phase model state
    logic        m_valid, m_write, m_cnd, m_halted;
    logic [31:0] m_valE;
    logic [2:0]  m_dst, m_cc;
    logic [3:0]  m_ic;

    initial begin
        logic [3:0]  halt_ics[2];
        logic        exp_ready, xfer;
        logic [3:0]  ic, fn;
        logic [31:0] a, b, c;
        logic [2:0]  d;
        res_t        r;

        vecs[0]  = '{4'h6, 4'h0, 32'h1, 32'h7FFFFFFF, 32'h0, 3'd3, 32'h80000000, 1, 3'd3, 0, 3'b011};
        vecs[1]  = '{4'h6, 4'h1, 32'h5, 32'h5, 32'h0, 3'd2, 32'h0, 1, 3'd2, 0, 3'b100};
        vecs[2]  = '{4'h7, 4'h1, 32'h0, 32'h0, 32'h40, 3'd0, 32'h0, 0, 3'd0, 1, 3'b100};
        vecs[3]  = '{4'h7, 4'h6, 32'h0, 32'h0, 32'h40, 3'd0, 32'h0, 0, 3'd0, 0, 3'b100};
        vecs[4]  = '{4'hA, 4'h0, 32'h9, 32'h100, 32'h0, 3'd1, 32'hFC, 1, 3'd4, 0, 3'b100};
        vecs[5]  = '{4'hB, 4'h0, 32'h9, 32'hFC, 32'h0, 3'd1, 32'h100, 1, 3'd4, 0, 3'b100};
        vecs[6]  = '{4'h3, 4'h0, 32'h0, 32'h0, 32'h12345678, 3'd1, 32'h12345678, 1, 3'd1, 0, 3'b100};
        vecs[7]  = '{4'h2, 4'h3, 32'hAAAA, 32'h0, 32'h0, 3'd5, 32'hAAAA, 1, 3'd5, 1, 3'b100};
        vecs[8]  = '{4'h2, 4'h4, 32'hAAAA, 32'h0, 32'h0, 3'd5, 32'hAAAA, 0, 3'd5, 0, 3'b100};
        vecs[9]  = '{4'h6, 4'h2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 3'd6, 32'h00F000F0, 1, 3'd6, 0,
                     3'b000};
        vecs[10] = '{4'h6, 4'h3, 32'hFFFFFFFF, 32'h80000000, 32'h0, 3'd7, 32'h7FFFFFFF, 1, 3'd7, 0,
                     3'b000};
        vecs[11] = '{4'h6, 4'h1, 32'h1, 32'h80000000, 32'h0, 3'd0, 32'h7FFFFFFF, 1, 3'd0, 0, 3'b001};
        vecs[12] = '{4'h7, 4'h2, 32'h0, 32'h0, 32'h0, 3'd0, 32'h0, 0, 3'd0, 1, 3'b001};
        vecs[13] = '{4'h7, 4'h5, 32'h0, 32'h0, 32'h0, 3'd0, 32'h0, 0, 3'd0, 0, 3'b001};
        vecs[14] = '{4'h4, 4'h0, 32'h3, 32'h1000, 32'h20, 3'd2, 32'h1020, 0, 3'd2, 0, 3'b001};
        vecs[15] = '{4'h8, 4'h0, 32'h3, 32'h200, 32'h0, 3'd2, 32'h1FC, 1, 3'd4, 0, 3'b001};
        vecs[16] = '{4'h9, 4'h0, 32'h3, 32'h1FC, 32'h0, 3'd2, 32'h200, 1, 3'd4, 0, 3'b001};
        vecs[17] = '{4'h1, 4'h0, 32'h3, 32'h5, 32'h0, 3'd2, 32'h0, 0, 3'd2, 0, 3'b001};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(4'h1, 4'h0, 32'h0, 32'h0, 32'h0, 3'd0);
        repeat (2) @(posedge CLK);
        #1;
        chk("reset out_valid", {31'd0, bus.out_valid}, 0);
        chk("reset valE", bus.valE_out, 0);
        chk("reset dstE", {29'd0, bus.dstE_out}, 0);
        chk("reset Write", {31'd0, bus.Write_out}, 0);
        chk("reset Cnd", {31'd0, bus.Cnd}, 0);
        chk("reset halted", {31'd0, bus.halted}, 0);
        chk("reset cc", {29'd0, bus.cc}, 32'h4);
        reset = 1'b1;

        // Directed vector table, one instruction per cycle, cc carried across rows
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].icode, vecs[i].ifun, vecs[i].valA, vecs[i].valB, vecs[i].valC,
                  vecs[i].dstE);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d in_ready", i), {31'd0, bus.in_ready}, 1);
            @(posedge CLK);
            #1;
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid}, 1);
            chk($sformatf("vec%0d valE", i), bus.valE_out, vecs[i].exp_valE);
            chk($sformatf("vec%0d Write", i), {31'd0, bus.Write_out}, {31'd0, vecs[i].exp_write});
            if (vecs[i].exp_write)
                chk($sformatf("vec%0d dstE", i), {29'd0, bus.dstE_out}, {29'd0, vecs[i].exp_dst});
            if (vecs[i].icode == 4'h2 || vecs[i].icode == 4'h7)
                chk($sformatf("vec%0d Cnd", i), {31'd0, bus.Cnd}, {31'd0, vecs[i].exp_cnd});
            chk($sformatf("vec%0d cc", i), {29'd0, bus.cc}, {29'd0, vecs[i].exp_cc});
        end
        @(posedge CLK);
        #1;
        chk("idle drain out_valid", {31'd0, bus.out_valid}, 0);

        // Backpressure: result held three cycles, then drains while the next is accepted
        bus.out_ready = 1'b0;
        drive(4'h3, 4'h0, 32'h0, 32'h0, 32'h11, 3'd1);
        bus.in_valid = 1'b1;
        @(posedge CLK);
        #1;
        drive(4'h3, 4'h0, 32'h0, 32'h0, 32'h22, 3'd2);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall in_ready", {31'd0, bus.in_ready}, 0);
            @(posedge CLK);
            #1;
            chk("stall out_valid", {31'd0, bus.out_valid}, 1);
            chk("stall valE", bus.valE_out, 32'h11);
            chk("stall dstE", {29'd0, bus.dstE_out}, 1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release in_ready", {31'd0, bus.in_ready}, 1);
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        chk("release out_valid", {31'd0, bus.out_valid}, 1);
        chk("release valE", bus.valE_out, 32'h22);
        chk("release dstE", {29'd0, bus.dstE_out}, 2);
        @(posedge CLK);
        #1;

        // Halt on icode 0 and on invalid icode C
        halt_ics[0] = 4'h0;
        halt_ics[1] = 4'hC;
        for (int h = 0; h < 2; h++) begin
            pulse_reset();
            bus.out_ready = 1'b0;
            drive(halt_ics[h], 4'h0, 32'h1, 32'h2, 32'h3, 3'd3);
            bus.in_valid = 1'b1;
            @(posedge CLK);
            #1;
            chk($sformatf("halt%0d out_valid", h), {31'd0, bus.out_valid}, 1);
            chk($sformatf("halt%0d Write", h), {31'd0, bus.Write_out}, 0);
            chk($sformatf("halt%0d halted", h), {31'd0, bus.halted}, 1);
            drive(4'h3, 4'h0, 32'h0, 32'h0, 32'h55, 3'd1);
            bus.out_ready = 1'b1;
            #1;
            chk($sformatf("halt%0d in_ready", h), {31'd0, bus.in_ready}, 0);
            @(posedge CLK);
            #1;
            chk($sformatf("halt%0d drained", h), {31'd0, bus.out_valid}, 0);
            chk($sformatf("halt%0d still halted", h), {31'd0, bus.halted}, 1);
            chk($sformatf("halt%0d in_ready held", h), {31'd0, bus.in_ready}, 0);
            bus.in_valid = 1'b0;
        end

        // Reset with a result pending
        pulse_reset();
        bus.out_ready = 1'b0;
        drive(4'h6, 4'h0, 32'h1, 32'h1, 32'h0, 3'd3);
        bus.in_valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        chk("mid pending valid", {31'd0, bus.out_valid}, 1);
        chk("mid pending cc", {29'd0, bus.cc}, 0);
        reset = 1'b0;
        #1;
        chk("mid reset out_valid", {31'd0, bus.out_valid}, 0);
        chk("mid reset Write", {31'd0, bus.Write_out}, 0);
        chk("mid reset cc", {29'd0, bus.cc}, 32'h4);
        #1;
        reset = 1'b1;

        // Randomized traffic against the model
        m_valid = 0; m_write = 0; m_cnd = 0; m_halted = 0;
        m_valE = '0; m_dst = '0; m_cc = 3'b100; m_ic = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (m_halted && !m_valid) begin
                pulse_reset();
                m_halted = 0;
                m_cc = 3'b100;
            end
            if ($urandom_range(0, 49) == 0) begin
                ic = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(12, 16) % 16);
                fn = (ic == 4'h6) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 15));
            end else begin
                ic = 4'($urandom_range(1, 11));
                fn = (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            end
            b = $urandom;
            case ($urandom_range(0, 3))
                0:       a = b;
                1:       a = 32'h80000000 ^ b;
                default: a = $urandom;
            endcase
            c = $urandom;
            d = 3'($urandom_range(0, 7));
            drive(ic, fn, a, b, c, d);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = !m_halted && (!m_valid || bus.out_ready);
            chk("rnd in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
            xfer = bus.in_valid && exp_ready;
            @(posedge CLK);
            if (xfer) begin
                r = model(ic, fn, a, b, c, d, m_cc);
                m_valid = 1;
                m_valE  = r.valE;
                m_write = r.write && !r.halt;
                m_dst   = r.dst;
                m_cnd   = r.cnd;
                m_cc    = r.cc;
                m_ic    = ic;
                if (r.halt) m_halted = 1;
            end else if (bus.out_ready) begin
                m_valid = 0;
            end
            #1;
            chk("rnd out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
            chk("rnd cc", {29'd0, bus.cc}, {29'd0, m_cc});
            chk("rnd halted", {31'd0, bus.halted}, {31'd0, m_halted});
            if (m_valid) begin
                chk("rnd valE", bus.valE_out, m_valE);
                chk("rnd Write", {31'd0, bus.Write_out}, {31'd0, m_write});
                if (m_write) chk("rnd dstE", {29'd0, bus.dstE_out}, {29'd0, m_dst});
                if (m_ic == 4'h2 || m_ic == 4'h7)
                    chk("rnd Cnd", {31'd0, bus.Cnd}, {31'd0, m_cnd});
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
